// File: rtl/gaussian_pkg.sv
// Shared FSM state type and 1-D Gaussian weight tables for gaussian_conv.
// Each table sums to 16, so any separable 2-D product sums to 256.
package gaussian_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    localparam int unsigned WT_W = 5;

    // Entries are packed so that index 0 is the leftmost tap.
    localparam logic [4:0][WT_W-1:0] W_K1    = {5'd0, 5'd0, 5'd0, 5'd0, 5'd16};
    localparam logic [4:0][WT_W-1:0] W_K3_S1 = {5'd0, 5'd0, 5'd4, 5'd8, 5'd4};
    localparam logic [4:0][WT_W-1:0] W_K3_S2 = {5'd0, 5'd0, 5'd5, 5'd6, 5'd5};
    localparam logic [4:0][WT_W-1:0] W_K5_S1 = {5'd1, 5'd4, 5'd6, 5'd4, 5'd1};
    localparam logic [4:0][WT_W-1:0] W_K5_S2 = {5'd3, 5'd3, 5'd4, 5'd3, 5'd3};

endpackage

// File: rtl/gaussian_kernel_rom.sv
// 1-D Gaussian weight lookup by sanitised kernel edge, sigma and tap index.
module gaussian_kernel_rom
    import gaussian_pkg::*;
(
    input  logic [2:0]      i_sigma,
    input  logic [2:0]      i_k,
    input  logic [2:0]      i_idx,
    output logic [WT_W-1:0] o_weight
);

    logic w_sharp;

    always_comb begin
        o_weight = '0;
        w_sharp  = (i_sigma <= 3'd1);
        case (i_k)
            3'd1:    o_weight = W_K1[i_idx];
            3'd3:    o_weight = w_sharp ? W_K3_S1[i_idx] : W_K3_S2[i_idx];
            3'd5:    o_weight = w_sharp ? W_K5_S1[i_idx] : W_K5_S2[i_idx];
            default: o_weight = '0;
        endcase
    end

endmodule

// File: rtl/gaussian_conv.sv
// Streaming Gaussian blur: per output pixel, K*K edge-clamped reads of the
// source RAM, weighted accumulation, rounding and one write to the result RAM.
module gaussian_conv
    import gaussian_pkg::*;
#(
    parameter int unsigned MAX_KERNEL  = 5,
    parameter int unsigned X_MAX       = 400,
    parameter int unsigned Y_MAX       = 400,
    parameter int unsigned PIXEL_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       new_trans,
    input  logic [$clog2(X_MAX)-1:0]   max_x,
    input  logic [$clog2(Y_MAX)-1:0]   max_y,
    input  logic [2:0]                 sigma,
    input  logic [7:0]                 kernel_size,
    output logic [$clog2(X_MAX):0]     x_addr_img,
    output logic [$clog2(Y_MAX):0]     y_addr_img,
    output logic                       ren_img,
    input  logic [PIXEL_DEPTH-1:0]     rdat_img,
    output logic [$clog2(X_MAX):0]     x_addr_conv,
    output logic [$clog2(Y_MAX):0]     y_addr_conv,
    output logic                       wen_conv,
    output logic [PIXEL_DEPTH-1:0]     wdat_conv,
    output logic                       pixel_done,
    output logic                       conv_done
);

    localparam int unsigned XW    = $clog2(X_MAX);
    localparam int unsigned YW    = $clog2(Y_MAX);
    localparam int unsigned XW1   = XW + 1;
    localparam int unsigned YW1   = YW + 1;
    localparam int unsigned KW    = $clog2(MAX_KERNEL + 1);
    localparam int unsigned PW    = 2 * WT_W;
    localparam int unsigned ACC_W = PIXEL_DEPTH + 9 + $clog2(MAX_KERNEL * MAX_KERNEL);

    state_t                 r_state, w_next;
    logic [2:0]             r_sigma;
    logic [KW-1:0]          r_k, r_dx, r_dy;
    logic [XW-1:0]          r_max_x, r_x;
    logic [YW-1:0]          r_max_y, r_y;
    logic [PW-1:0]          r_wt_d;
    logic                   r_wt_vld;
    logic [ACC_W-1:0]       r_acc;

    logic [7:0]             w_k_odd;
    logic [KW-1:0]          w_k_in, w_half;
    logic [2:0]             w_sigma_in;
    logic                   w_empty, w_last_col, w_last_tap, w_last_pix;
    logic [XW1-1:0]         w_sx, w_tx_raw;
    logic [YW1-1:0]         w_sy, w_ty_raw;
    logic [XW-1:0]          w_tx;
    logic [YW-1:0]          w_ty;
    logic [WT_W-1:0]        w_wx, w_wy;
    logic [PW-1:0]          w_wt;
    logic [ACC_W-1:0]       w_rnd, w_q;
    logic [PIXEL_DEPTH-1:0] w_res;

    // Kernel edge sanitising: 0 -> 1, even -> next lower odd, then cap.
    always_comb begin
        w_k_odd = kernel_size;
        if (kernel_size == 8'd0)
            w_k_odd = 8'd1;
        else if (!kernel_size[0])
            w_k_odd = kernel_size - 8'd1;
        w_k_in     = (w_k_odd > 8'(MAX_KERNEL)) ? KW'(MAX_KERNEL) : KW'(w_k_odd);
        w_sigma_in = (sigma == 3'd0) ? 3'd1 : sigma;
    end

    assign w_empty    = (max_x == '0) || (max_y == '0);
    assign w_last_col = (r_dx == r_k - KW'(1));
    assign w_last_tap = w_last_col && (r_dy == r_k - KW'(1));
    assign w_last_pix = (r_x == r_max_x - XW'(1)) && (r_y == r_max_y - YW'(1));
    assign w_half     = (r_k - KW'(1)) >> 1;

    // Tap coordinate is pos + idx - half; clamping against half first avoids signed math.
    always_comb begin
        w_sx     = {1'b0, r_x} + XW1'(r_dx);
        w_sy     = {1'b0, r_y} + YW1'(r_dy);
        w_tx_raw = w_sx - XW1'(w_half);
        w_ty_raw = w_sy - YW1'(w_half);
        if (w_sx < XW1'(w_half))
            w_tx = '0;
        else if (w_tx_raw >= {1'b0, r_max_x})
            w_tx = r_max_x - XW'(1);
        else
            w_tx = w_tx_raw[XW-1:0];
        if (w_sy < YW1'(w_half))
            w_ty = '0;
        else if (w_ty_raw >= {1'b0, r_max_y})
            w_ty = r_max_y - YW'(1);
        else
            w_ty = w_ty_raw[YW-1:0];
    end

    gaussian_kernel_rom u_rom_x (
        .i_sigma  (r_sigma),
        .i_k      (3'(r_k)),
        .i_idx    (3'(r_dx)),
        .o_weight (w_wx)
    );

    gaussian_kernel_rom u_rom_y (
        .i_sigma  (r_sigma),
        .i_k      (3'(r_k)),
        .i_idx    (3'(r_dy)),
        .o_weight (w_wy)
    );

    assign w_wt  = PW'(w_wx) * PW'(w_wy);
    assign w_rnd = r_acc + ACC_W'(128);
    assign w_q   = w_rnd >> 8;
    assign w_res = (w_q > ACC_W'(2 ** PIXEL_DEPTH - 1)) ? '1 : w_q[PIXEL_DEPTH-1:0];

    always_ff @(posedge clk) begin
        if (n_rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        ren_img     = 1'b0;
        x_addr_img  = '0;
        y_addr_img  = '0;
        wen_conv    = 1'b0;
        x_addr_conv = '0;
        y_addr_conv = '0;
        wdat_conv   = '0;
        pixel_done  = 1'b0;
        conv_done   = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                conv_done = (r_state == DONE);
                if (new_trans)
                    w_next = w_empty ? DONE : READ;
            end
            READ: begin
                ren_img    = 1'b1;
                x_addr_img = XW1'(w_tx);
                y_addr_img = YW1'(w_ty);
                if (w_last_tap)
                    w_next = DRAIN;
            end
            DRAIN: w_next = WRITE;
            WRITE: begin
                wen_conv    = 1'b1;
                pixel_done  = 1'b1;
                x_addr_conv = XW1'(r_x);
                y_addr_conv = YW1'(r_y);
                wdat_conv   = w_res;
                w_next      = w_last_pix ? DONE : READ;
            end
            default: w_next = IDLE;
        endcase
    end

    // Weight is delayed one cycle to line up with the synchronous RAM read data.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_sigma  <= '0;
            r_k      <= '0;
            r_max_x  <= '0;
            r_max_y  <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_wt_d   <= '0;
            r_wt_vld <= 1'b0;
            r_acc    <= '0;
        end else begin
            r_wt_vld <= (r_state == READ);
            r_wt_d   <= w_wt;
            if (r_wt_vld)
                r_acc <= r_acc + ACC_W'(rdat_img) * ACC_W'(r_wt_d);
            case (r_state)
                IDLE, DONE: begin
                    if (new_trans) begin
                        r_sigma <= w_sigma_in;
                        r_k     <= w_k_in;
                        r_max_x <= max_x;
                        r_max_y <= max_y;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_dx    <= '0;
                        r_dy    <= '0;
                        r_acc   <= '0;
                    end
                end
                READ: begin
                    if (w_last_col) begin
                        r_dx <= '0;
                        r_dy <= r_dy + KW'(1);
                    end else begin
                        r_dx <= r_dx + KW'(1);
                    end
                end
                WRITE: begin
                    r_acc <= '0;
                    r_dx  <= '0;
                    r_dy  <= '0;
                    if (r_x == r_max_x - XW'(1)) begin
                        r_x <= '0;
                        r_y <= r_y + YW'(1);
                    end else begin
                        r_x <= r_x + XW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gaussian_conv.sv
// Directed bench for gaussian_conv with a synchronous-read image RAM model
// and a result RAM capture; expected values are hand-computed.
module tb_gaussian_conv;

    localparam int unsigned XW = 9;
    localparam int unsigned YW = 9;
    localparam int unsigned PD = 8;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          new_trans;
    logic [XW-1:0] max_x;
    logic [YW-1:0] max_y;
    logic [2:0]    sigma;
    logic [7:0]    kernel_size;
    logic [XW:0]   x_addr_img, x_addr_conv;
    logic [YW:0]   y_addr_img, y_addr_conv;
    logic          ren_img, wen_conv, pixel_done, conv_done;
    logic [PD-1:0] rdat_img, wdat_conv;

    logic [7:0] img [16][16];
    logic [7:0] res [16][16];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0, nwr = 0, nrd = 0, npd = 0, prev_pd = 0, gap = 0;
    int last_wx = 0, last_wy = 0;
    int base_wr, base_rd, base_pd, bad, k;

    always #5 clk = ~clk;

    gaussian_conv #(
        .MAX_KERNEL  (5),
        .X_MAX       (400),
        .Y_MAX       (400),
        .PIXEL_DEPTH (PD)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .new_trans   (new_trans),
        .max_x       (max_x),
        .max_y       (max_y),
        .sigma       (sigma),
        .kernel_size (kernel_size),
        .x_addr_img  (x_addr_img),
        .y_addr_img  (y_addr_img),
        .ren_img     (ren_img),
        .rdat_img    (rdat_img),
        .x_addr_conv (x_addr_conv),
        .y_addr_conv (y_addr_conv),
        .wen_conv    (wen_conv),
        .wdat_conv   (wdat_conv),
        .pixel_done  (pixel_done),
        .conv_done   (conv_done)
    );

    always @(posedge clk) begin
        if (ren_img)
            rdat_img <= img[y_addr_img[3:0]][x_addr_img[3:0]];
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (ren_img)
            nrd = nrd + 1;
        if (wen_conv) begin
            res[y_addr_conv[3:0]][x_addr_conv[3:0]] = wdat_conv;
            last_wx = int'(x_addr_conv);
            last_wy = int'(y_addr_conv);
            nwr = nwr + 1;
        end
        if (pixel_done) begin
            npd = npd + 1;
            gap = cyc - prev_pd;
            prev_pd = cyc;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_img(input int mode);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) begin
                case (mode)
                    0: img[y][x] = 8'd100;
                    1: img[y][x] = (x == 8 && y == 8) ? 8'd255 : 8'd0;
                    2: img[y][x] = 8'(x * 7 + y * 13 + 3);
                    default: img[y][x] = (x < 4 && y < 4) ? 8'(10 * x + 40 * y) : 8'd0;
                endcase
                res[y][x] = 8'hEE;
            end
    endtask

    task automatic start_frame(input int mx, input int my, input int sg, input int ks);
        @(negedge clk);
        max_x       = XW'(mx);
        max_y       = YW'(my);
        sigma       = 3'(sg);
        kernel_size = 8'(ks);
        base_wr     = nwr;
        base_rd     = nrd;
        base_pd     = npd;
        new_trans   = 1'b1;
        @(negedge clk);
        new_trans   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!conv_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, int'(conv_done), 1);
    endtask

    initial begin
        n_rst = 1'b1;
        new_trans = 1'b0;
        max_x = '0;
        max_y = '0;
        sigma = '0;
        kernel_size = '0;
        repeat (3) @(negedge clk);
        check("rst_ren", int'(ren_img), 0);
        check("rst_wen", int'(wen_conv), 0);
        check("rst_pdone", int'(pixel_done), 0);
        check("rst_cdone", int'(conv_done), 0);
        check("rst_wdat", int'(wdat_conv), 0);
        n_rst = 1'b0;
        @(negedge clk);

        // Constant 100, K=3, sigma 2
        fill_img(0);
        start_frame(16, 16, 2, 3);
        wait_done("const_done", 4000);
        check("const_writes", nwr - base_wr, 256);
        check("const_pdone", npd - base_pd, 256);
        check("const_gap", gap, 11);
        bad = 0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                if (res[y][x] != 8'd100) bad++;
        check("const_bad", bad, 0);
        repeat (3) @(negedge clk);
        check("const_hold", int'(conv_done), 1);

        // Impulse, K=3, sigma 1
        fill_img(1);
        start_frame(16, 16, 1, 3);
        wait_done("imp3_done", 4000);
        check("imp3_c", int'(res[8][8]), 64);
        check("imp3_w", int'(res[8][7]), 32);
        check("imp3_nw", int'(res[7][7]), 16);
        bad = 0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                if ((x < 7 || x > 9 || y < 7 || y > 9) && res[y][x] != 8'd0) bad++;
        check("imp3_outside", bad, 0);

        // K=1 is identity, 3 cycles per pixel
        fill_img(2);
        start_frame(16, 16, 3, 1);
        wait_done("k1_done", 2000);
        bad = 0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                if (res[y][x] != img[y][x]) bad++;
        check("k1_bad", bad, 0);
        check("k1_gap", gap, 3);
        check("k1_reads", nrd - base_rd, 256);

        // 4x4 ramp 10*x+40*y, K=5, sigma 1, edge-clamped
        fill_img(3);
        start_frame(4, 4, 1, 5);
        wait_done("ramp_done", 1000);
        check("ramp_00", int'(res[0][0]), 19);
        check("ramp_33", int'(res[3][3]), 131);
        check("ramp_gap", gap, 27);
        check("ramp_writes", nwr - base_wr, 16);

        // kernel_size 4 and sigma 0 behave as K=3 sigma 1
        fill_img(1);
        start_frame(16, 16, 0, 4);
        wait_done("k4_done", 4000);
        check("k4_c", int'(res[8][8]), 64);
        check("k4_w", int'(res[8][7]), 32);
        check("k4_gap", gap, 11);

        // kernel_size 7 behaves as K=5
        fill_img(1);
        start_frame(16, 16, 1, 7);
        wait_done("k7_done", 8000);
        check("k7_c", int'(res[8][8]), 36);
        check("k7_w2", int'(res[8][6]), 6);
        check("k7_gap", gap, 27);

        // Empty image
        start_frame(0, 16, 1, 3);
        wait_done("empty_done", 5);
        repeat (5) @(negedge clk);
        check("empty_reads", nrd - base_rd, 0);
        check("empty_writes", nwr - base_wr, 0);

        // Reset during READ of pixel 10, then restart
        fill_img(0);
        start_frame(16, 16, 2, 3);
        k = 0;
        while (npd - base_pd < 10 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("mid_reach10", npd - base_pd, 10);
        repeat (3) @(negedge clk);
        check("mid_in_read", int'(ren_img), 1);
        n_rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ren", int'(ren_img), 0);
        check("mid_rst_wen", int'(wen_conv), 0);
        check("mid_rst_xaddr", int'(x_addr_img), 0);
        n_rst = 1'b0;
        base_wr = nwr;
        repeat (40) @(negedge clk);
        check("mid_no_write", nwr - base_wr, 0);
        check("mid_no_done", int'(conv_done), 0);
        start_frame(16, 16, 2, 3);
        k = 0;
        while (nwr == base_wr && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("restart_x", last_wx, 0);
        check("restart_y", last_wy, 0);
        wait_done("restart_done", 4000);
        check("restart_writes", nwr - base_wr, 256);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gaussian_conv.md
GAUSSIAN_CONV -- requirements
Module: gaussian_conv

Interface
REQ-001 SHALL have parameter MAX_KERNEL, default 5: largest supported kernel edge.
REQ-002 SHALL have parameter X_MAX, default 400: maximum image width.
REQ-003 SHALL have parameter Y_MAX, default 400: maximum image height.
REQ-004 SHALL have parameter PIXEL_DEPTH, default 8: pixel bit width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port n_rst, input, 1 bit: reset, synchronous and active-high (1 resets on the next clk edge), named per codebase convention.
REQ-007 SHALL have port new_trans, input, 1 bit: one-cycle start pulse.
REQ-008 SHALL have ports max_x and max_y, inputs, $clog2(X_MAX) and $clog2(Y_MAX) bits: image width and height.
REQ-009 SHALL have ports sigma (input, 3 bits) and kernel_size (input, 8 bits): Gaussian sigma and kernel edge.
REQ-010 SHALL have outputs x_addr_img and y_addr_img ($clog2(X_MAX)+1 and $clog2(Y_MAX)+1 bits) and ren_img (1 bit), plus input rdat_img (PIXEL_DEPTH bits): source image RAM read port.
REQ-011 SHALL have outputs x_addr_conv and y_addr_conv (same widths), wen_conv (1 bit) and wdat_conv (PIXEL_DEPTH bits): result RAM write port.
REQ-012 SHALL have outputs pixel_done and conv_done, 1 bit each: status.
REQ-013 SHALL treat the image RAM (sram_image) as synchronous-read: rdat_img is valid on the cycle after ren_img is high at that address.

Function
REQ-014 SHALL, in IDLE, latch sigma, kernel_size, max_x and max_y on new_trans=1, clear conv_done, start at pixel (0,0) and enter READ.
REQ-015 SHALL sanitise the kernel edge K: 0 gives 1; an even value rounds down to the next odd value; any value above MAX_KERNEL gives MAX_KERNEL.
REQ-016 SHALL sanitise sigma: 0 is treated as 1.
REQ-017 SHALL visit output pixels row-major: x 0..max_x-1 inner loop, y 0..max_y-1 outer loop.
REQ-018 SHALL, in READ, issue one ren_img per cycle for the K*K taps at (x+dx, y+dy), dx and dy from -(K-1)/2 to +(K-1)/2, row-major.
REQ-019 SHALL clamp each tap coordinate into 0..max-1 (edge replication).
REQ-020 SHALL compute each tap weight as w[dx]*w[dy], using the 1-D weights below (each table sums to 16, so the 2-D weights sum to 256):
- K=1: [16]
- K=3: sigma 1 [4,8,4]; sigma 2 or more [5,6,5]
- K=5: sigma 1 [1,4,6,4,1]; sigma 2 or more [3,3,4,3,3]
REQ-021 SHALL multiply each returned rdat_img by its weight, one cycle after the read, and accumulate in a register of at least PIXEL_DEPTH+8+ceil(log2(MAX_KERNEL^2)) bits; the accumulator is cleared per pixel.
REQ-022 SHALL compute the result as (acc+128)>>8, saturated to 2^PIXEL_DEPTH-1.
REQ-023 SHALL, in WRITE, drive wen_conv=1, x_addr_conv=x, y_addr_conv=y and wdat_conv=result, and pulse pixel_done, all for exactly one cycle.
REQ-024 SHALL take exactly K*K+2 cycles per pixel: K*K read cycles, one drain cycle, one write cycle.
REQ-025 SHALL, after the write of pixel (max_x-1, max_y-1), enter DONE and hold conv_done=1 until the next new_trans.
REQ-026 SHALL ignore new_trans outside IDLE and DONE.
REQ-027 SHALL treat max_x=0 or max_y=0 as an empty image: go directly to DONE with no reads or writes.
REQ-028 SHALL deassert ren_img and wen_conv in every state that does not use them; the address outputs are don't-care while their enable is low.

Reset
REQ-029 SHALL, while n_rst=1 at a clk edge, go to IDLE and clear all outputs, counters, the accumulator and latched configuration to 0.
REQ-030 SHALL, on reset mid-operation, abort the frame with no further write and not assert conv_done.

Structure
REQ-031 SHALL place the state enum (IDLE, READ, DRAIN, WRITE, DONE) and the weight-table constants in a shared package gaussian_pkg.
REQ-032 SHALL implement the weight lookup as one sub-module, gaussian_kernel_rom (inputs: sigma, K, tap index; output: 1-D weight).
REQ-033 SHALL take sram_image as an existing memory model, not part of this block.

Verification
REQ-034 SHALL cover: 16x16 image of constant 100, K=3, sigma=2 -> all 256 outputs 100, 256 pixel_done pulses, then conv_done=1.
REQ-035 SHALL cover: 16x16 image with a single 255 at (8,8), others 0, K=3, sigma=1 -> (8,8)=64, (7,8)=32, (7,7)=16, and 0 outside the 3x3 window.
REQ-036 SHALL cover: K=1 on any image -> output identical to input; each pixel takes 3 cycles.
REQ-037 SHALL cover: 4x4 ramp image, K=5, pixel (0,0) -> result matches edge-clamped reference arithmetic bit-exact.
REQ-038 SHALL cover: kernel_size=4 or 7 -> behaves as K=3 or K=5 respectively.
REQ-039 SHALL cover: n_rst=1 during READ of pixel 10 -> outputs 0 and no further wen_conv; a later new_trans restarts the frame from (0,0).
